ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-requester access controller for the 8-bit single-port data RAM. It shares the RAM write and read ports between requester A (CPU load/store unit) and requester B (DMA/IO engine) using round-robin arbitration. It sequences each accepted access as a registered RAM command and returns read data with a valid pulse. It sits between the core and the RAM, and drives every RAM control and address pin.

Parameters:
addr_size, 8, RAM address width
data_size, 8, RAM data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
req_a  input  1  requester A access request
we_a  input  1  A: 1 = write, 0 = read
addr_a  input  addr_size  A address
wdata_a  input  data_size  A write data
gnt_a  output  1  A command accepted, 1-cycle pulse
rvalid_a  output  1  A read data valid, 1-cycle pulse
rdata_a  output  data_size  A read data, held until next A read
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
mem_write_en  output  1  RAM write enable
mem_write_adress  output  addr_size  RAM write address
mem_data_in  output  data_size  RAM write data
mem_rd_en  output  1  RAM read enable
mem_rd_adress  output  addr_size  RAM read address
mem_data_out  input  data_size  RAM registered read data (valid 1 cycle after mem_rd_en)
busy  output  1  high when state is not IDLE

Behaviour:
- Reset (rst=0, async) applies these values:
  - All outputs 0.
  - State = IDLE.
  - Latched command cleared.
  - last_grant = B, so A wins the first tie.
- States: IDLE, ISSUE, CAPTURE.
- IDLE: requests are sampled at each rising edge.
  - If either req is high: latch we/addr/wdata of the winner, set its gnt for the next cycle, go to ISSUE.
  - If neither req is high: stay in IDLE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - last_grant updates to the winner on every acceptance.
- ISSUE, one cycle:
  - gnt of the winner = 1.
  - Latched write: mem_write_en=1, mem_write_adress=addr, mem_data_in=wdata; next state IDLE.
  - Latched read: mem_rd_en=1, mem_rd_adress=addr; next state CAPTURE.
  - mem_* are registered outputs: they are high only during ISSUE and 0 in all other cycles.
- CAPTURE, one cycle: rdata of the owner <= mem_data_out at the end of the cycle; next state IDLE; rvalid of the owner = 1 in the following cycle.
- Timing with request sampled at edge 0:
  - gnt in cycle 1.
  - Write: committed at edge 1; next request sampled at edge 2.
  - Read: rvalid/rdata in cycle 3; next request sampled at edge 3, so the rvalid cycle overlaps IDLE.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until gnt is seen.
  - Requester deasserts req in the gnt cycle unless it issues a new access.
  - req sampled in ISSUE/CAPTURE is ignored; it is re-evaluated in IDLE.
  - The losing requester keeps req high and is served next, so no starvation occurs.
- rdata_x is updated only on its own read; the other requester's rdata is unchanged.
- Reset mid-operation: the in-flight access is aborted, and a write in ISSUE is not committed once rst falls. The arbiter does not drive the RAM's own reset.
- Address and data pass through unmodified; no wrap or width arithmetic.

Optional Feature:
RAM_ARB_FIXED_PRIO_EN
- Defined: A always wins when both request; last_grant is still maintained but ignored. B can starve.
- Undefined: round-robin as above.

Decomposition:
- Package ram_arb_pkg:
  - State typedef (IDLE, ISSUE, CAPTURE).
  - Requester id constants REQ_A=1'b0, REQ_B=1'b1.
- Sub-module rr_arb2: two-input round-robin picker.
  - Inputs: req_a, req_b, last_grant.
  - Outputs: valid, winner id.
  - Purely combinational; fixed-priority variant selected by the macro.

Test Plan:
- Reset: hold rst=0 with req_a=1 -> all outputs 0, busy=0; release -> first edge samples A.
- A writes 0x5A to 0x10, then A reads 0x10 -> gnt_a in cycle 1, mem_write_en one cycle at addr 0x10; read gives rvalid_a=1 with rdata_a=0x5A exactly 3 cycles after the sampling edge.
- req_a and req_b both held high continuously after reset, reads of 0x01/0x02 -> grants alternate A,B,A,B; rdata_b unchanged during A reads.
- B writes 0xFF to 0xFF (top address), then B reads 0xFF -> rdata_b=0xFF; no mem_* activity outside ISSUE cycles.
- rst asserted during ISSUE of an A write of 0x33 to 0x20 -> mem_write_en drops immediately, state IDLE; a later read of 0x20 returns the prior contents, not 0x33.
- With RAM_ARB_FIXED_PRIO_EN, both requesting for 4 accesses -> gnt_a every time, gnt_b never.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM access controller.
// Optional build macro RAM_ARB_FIXED_PRIO_EN selects fixed A-first priority.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin picker; purely combinational.
// RAM_ARB_FIXED_PRIO_EN makes A win every tie (last_grant is then ignored).
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick the winner; ties go to whoever was not granted last
    always_comb begin
        valid  = req_a | req_b;
        winner = REQ_A;
        if (req_a && req_b) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            winner = REQ_A;
`else
            winner = (last_grant == REQ_A) ? REQ_B : REQ_A;
`endif
        end else if (req_b) begin
            winner = REQ_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between requester A and requester B.
// Build macro RAM_ARB_FIXED_PRIO_EN switches arbitration to fixed A-first.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int addr_size = 8,
    parameter int data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a,
    input  logic                 we_a,
    input  logic [addr_size-1:0] addr_a,
    input  logic [data_size-1:0] wdata_a,
    output logic                 gnt_a,
    output logic                 rvalid_a,
    output logic [data_size-1:0] rdata_a,
    input  logic                 req_b,
    input  logic                 we_b,
    input  logic [addr_size-1:0] addr_b,
    input  logic [data_size-1:0] wdata_b,
    output logic                 gnt_b,
    output logic                 rvalid_b,
    output logic [data_size-1:0] rdata_b,
    output logic                 mem_write_en,
    output logic [addr_size-1:0] mem_write_adress,
    output logic [data_size-1:0] mem_data_in,
    output logic                 mem_rd_en,
    output logic [addr_size-1:0] mem_rd_adress,
    input  logic [data_size-1:0] mem_data_out,
    output logic                 busy
);

    state_t state;
    state_t state_next;

    logic last_grant;
    logic cmd_owner;
    logic cmd_we;

    logic arb_valid;
    logic arb_winner;
    logic accept;
    logic capture;

    logic                 sel_we;
    logic [addr_size-1:0] sel_addr;
    logic [data_size-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign sel_we    = (arb_winner == REQ_B) ? we_b    : we_a;
    assign sel_addr  = (arb_winner == REQ_B) ? addr_b  : addr_a;
    assign sel_wdata = (arb_winner == REQ_B) ? wdata_b : wdata_a;

    assign capture = (state == CAPTURE);
    assign busy    = (state != IDLE);

    // Next-state logic; requests are only looked at while idle
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = ISSUE;
                    accept     = 1'b1;
                end
            end
            ISSUE:   state_next = cmd_we ? IDLE : CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched command, grant/RAM command registers and read return path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant       <= REQ_B;
            cmd_owner        <= REQ_A;
            cmd_we           <= 1'b0;
            gnt_a            <= 1'b0;
            gnt_b            <= 1'b0;
            rvalid_a         <= 1'b0;
            rvalid_b         <= 1'b0;
            rdata_a          <= '0;
            rdata_b          <= '0;
            mem_write_en     <= 1'b0;
            mem_write_adress <= '0;
            mem_data_in      <= '0;
            mem_rd_en        <= 1'b0;
            mem_rd_adress    <= '0;
        end else begin
            if (accept) begin
                last_grant <= arb_winner;
                cmd_owner  <= arb_winner;
                cmd_we     <= sel_we;
            end
            gnt_a        <= accept && (arb_winner == REQ_A);
            gnt_b        <= accept && (arb_winner == REQ_B);
            mem_write_en <= accept && sel_we;
            mem_rd_en    <= accept && !sel_we;
            mem_write_adress <= (accept && sel_we)  ? sel_addr  : '0;
            mem_data_in      <= (accept && sel_we)  ? sel_wdata : '0;
            mem_rd_adress    <= (accept && !sel_we) ? sel_addr  : '0;
            rvalid_a <= capture && (cmd_owner == REQ_A);
            rvalid_b <= capture && (cmd_owner == REQ_B);
            if (capture && (cmd_owner == REQ_A)) begin
                rdata_a <= mem_data_out;
            end
            if (capture && (cmd_owner == REQ_B)) begin
                rdata_b <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a registered-read RAM model.
// Build with RAM_ARB_FIXED_PRIO_EN to expect fixed A-first arbitration.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic       clk;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
    logic       gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic       mem_write_en, mem_rd_en, busy;
    logic [7:0] mem_write_adress, mem_data_in, mem_rd_adress;
    logic [7:0] mem_data_out;

    ram_arbiter #(.addr_size(8), .data_size(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_a            (req_a),
        .we_a             (we_a),
        .addr_a           (addr_a),
        .wdata_a          (wdata_a),
        .gnt_a            (gnt_a),
        .rvalid_a         (rvalid_a),
        .rdata_a          (rdata_a),
        .req_b            (req_b),
        .we_b             (we_b),
        .addr_b           (addr_b),
        .wdata_b          (wdata_b),
        .gnt_b            (gnt_b),
        .rvalid_b         (rvalid_b),
        .rdata_b          (rdata_b),
        .mem_write_en     (mem_write_en),
        .mem_write_adress (mem_write_adress),
        .mem_data_in      (mem_data_in),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_adress    (mem_rd_adress),
        .mem_data_out     (mem_data_out),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: preloaded on the very first edge, registered read
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h01] <= 8'h11;
            ram[8'h02] <= 8'h22;
            ram[8'h20] <= 8'h44;
        end else begin
            if (mem_write_en) ram[mem_write_adress] <= mem_data_in;
            if (mem_rd_en) mem_data_out <= ram[mem_rd_adress];
        end
    end

    typedef struct {
        bit         kind;
        bit         id;
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] hold_a = 8'h00;
    logic [7:0] hold_b = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h",
                     nm, cyc, act, req);
        end
    endtask

    task automatic take(input bit kind, input bit id);
        exp_t e;
        if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event at cycle %0d: got kind=%0d id=%0d, required none",
                     cyc, kind, id);
            return;
        end
        e = sbq.pop_front();
        chk("event_kind_id", {30'd0, kind, id}, {30'd0, e.kind, e.id});
        chk("event_cycle", cyc, e.cyc);
        if (!kind) begin
            chk("mem_write_en", mem_write_en, e.we);
            chk("mem_rd_en", mem_rd_en, !e.we);
            if (e.we) begin
                chk("mem_write_adress", mem_write_adress, e.addr);
                chk("mem_data_in", mem_data_in, e.data);
            end else begin
                chk("mem_rd_adress", mem_rd_adress, e.addr);
            end
        end else if (id == REQ_A) begin
            chk("rdata_a", rdata_a, e.data);
            hold_a = e.data;
            chk("rdata_b_held", rdata_b, hold_b);
        end else begin
            chk("rdata_b", rdata_b, e.data);
            hold_b = e.data;
            chk("rdata_a_held", rdata_a, hold_a);
        end
    endtask

    // Monitor: every grant / read return is matched against the queue
    always @(negedge clk) begin
        if (gnt_a) take(1'b0, REQ_A);
        if (gnt_b) take(1'b0, REQ_B);
        if (rvalid_a) take(1'b1, REQ_A);
        if (rvalid_b) take(1'b1, REQ_B);
        if (!(gnt_a || gnt_b))
            chk("mem_quiet_outside_issue", {mem_write_en, mem_rd_en}, 0);
    end

    task automatic drive(input bit id, input bit we, input logic [7:0] addr,
                         input logic [7:0] wd);
        if (id == REQ_B) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
        end
    endtask

    task automatic push_acc(input bit id, input bit we, input logic [7:0] addr,
                            input logic [7:0] wd, input logic [7:0] rd,
                            input int s);
        sbq.push_back('{1'b0, id, we, addr, (we ? wd : 8'h00), s});
        if (!we) sbq.push_back('{1'b1, id, 1'b0, addr, rd, s + 2});
    endtask

    task automatic start(input bit id, input bit we, input logic [7:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd);
        int k;
        k = cyc;
        drive(id, we, addr, wd);
        push_acc(id, we, addr, wd, rd, k + 1);
    endtask

    task automatic complete(input bit id, input bit we);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = (id == REQ_B) ? gnt_b : gnt_a;
        end
        chk("gnt_wait", {31'd0, seen}, 1);
        if (id == REQ_B) req_b = 1'b0;
        else req_a = 1'b0;
        if (we) begin
            @(negedge clk);
        end else begin
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                seen = (id == REQ_B) ? rvalid_b : rvalid_a;
            end
            chk("rvalid_wait", {31'd0, seen}, 1);
        end
    endtask

    initial begin
        int k;
        bit w [4];
        rst = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
        req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;

        // Reset held with A requesting a write of 0x5A to 0x10
        drive(REQ_A, 1'b1, 8'h10, 8'h5A);
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {gnt_a, gnt_b, rvalid_a, rvalid_b,
                         mem_write_en, mem_rd_en, busy}, 0);
        chk("rst_rdata", {rdata_a, rdata_b}, 0);
        chk("rst_mem_bus", {mem_write_adress, mem_data_in, mem_rd_adress}, 0);
        k = cyc;
        push_acc(REQ_A, 1'b1, 8'h10, 8'h5A, 8'h00, k + 1);
        rst = 1'b1;
        complete(REQ_A, 1'b1);

        // A reads back 0x10
        start(REQ_A, 1'b0, 8'h10, 8'h00, 8'h5A);
        complete(REQ_A, 1'b0);

        // Fresh reset, then both requesters hold reads continuously
        rst = 1'b0;
        hold_a = 8'h00;
        hold_b = 8'h00;
        drive(REQ_A, 1'b0, 8'h01, 8'h00);
        drive(REQ_B, 1'b0, 8'h02, 8'h00);
`ifdef RAM_ARB_FIXED_PRIO_EN
        w = '{REQ_A, REQ_A, REQ_A, REQ_A};
`else
        w = '{REQ_A, REQ_B, REQ_A, REQ_B};
`endif
        @(negedge clk);
        k = cyc;
        for (int j = 0; j < 4; j++) begin
            push_acc(w[j], 1'b0, (w[j] == REQ_B) ? 8'h02 : 8'h01, 8'h00,
                     (w[j] == REQ_B) ? 8'h22 : 8'h11, k + 1 + 3 * j);
        end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) @(negedge clk);

        // B writes and reads the top address
        start(REQ_B, 1'b1, 8'hFF, 8'hFF, 8'h00);
        complete(REQ_B, 1'b1);
        start(REQ_B, 1'b0, 8'hFF, 8'h00, 8'hFF);
        complete(REQ_B, 1'b0);

        // Reset lands in the ISSUE cycle of an A write of 0x33 to 0x20
        drive(REQ_A, 1'b1, 8'h20, 8'h33);
        @(posedge clk);
        #2;
        chk("issue_write_en", mem_write_en, 1);
        rst = 1'b0;
        req_a = 1'b0;
        #1;
        chk("abort_write_en", mem_write_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gnt_a", gnt_a, 0);
        hold_a = 8'h00;
        hold_b = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start(REQ_A, 1'b0, 8'h20, 8'h00, 8'h44);
        complete(REQ_A, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
